// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Sizes of the file, the load buffer and the starvation limit live here.
package regfile_write_arbiter_pkg;
    localparam int NREG     = 16;
    localparam int W        = 16;
    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;
    localparam int BUF_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BUF_CW   = $clog2(DEPTH + 1);

    typedef logic [3:0]   reg_addr_t;
    typedef logic [W-1:0] data_t;

    typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;

    typedef struct packed {
        reg_addr_t addr;
        data_t     data;
    } wentry_t;

    // R0 decodes to no enable at all: the file's zero register has no cell.
    function automatic logic [NREG-1:0] reg_onehot(input reg_addr_t a);
        logic [NREG-1:0] oh;
        oh = '0;
        if (a != '0) oh[a] = 1'b1;
        return oh;
    endfunction
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Write-request bundle from the ALU writeback and load-return sources.
// master = request sources, slave = the arbiter.
interface regfile_write_arbiter_if;
    import regfile_write_arbiter_pkg::*;

    logic      alu_we;
    reg_addr_t alu_waddr;
    data_t     alu_wdata;
    logic      alu_stall;

    logic      ld_valid;
    logic      ld_ready;
    reg_addr_t ld_waddr;
    data_t     ld_wdata;

    modport master (
        output alu_we, alu_waddr, alu_wdata, ld_valid, ld_waddr, ld_wdata,
        input  alu_stall, ld_ready
    );

    modport slave (
        input  alu_we, alu_waddr, alu_wdata, ld_valid, ld_waddr, ld_wdata,
        output alu_stall, ld_ready
    );
endinterface

// File: rtl/regfile_wbuf.sv
// Load-write buffer: DEPTH-entry FIFO of {addr, data} with per-entry pend compare.
// Latency: push visible at head next cycle; pend flags combinational from rs1/rs2.
// Backpressure: caller must not push when full; flush overrides push and pop.
module regfile_wbuf
    import regfile_write_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  wentry_t           push_ent,
    input  logic              pop,
    output wentry_t           head,
    output logic              empty,
    output logic              full,
    output logic [BUF_CW-1:0] cnt,
    input  reg_addr_t         rs1,
    input  reg_addr_t         rs2,
    output logic              rs1_pend,
    output logic              rs2_pend
);
    typedef logic [BUF_AW-1:0] ptr_t;

    wentry_t          mem [DEPTH];
    logic [DEPTH-1:0] vld;
    ptr_t             rd_ptr;
    ptr_t             wr_ptr;

    function automatic ptr_t ptr_next(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            vld    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= ptr_next(rd_ptr);
            end
            if (push) begin
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= ptr_next(wr_ptr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_ent;
    end

    assign head  = mem[rd_ptr];
    assign empty = !vld[rd_ptr];
    assign full  = vld[wr_ptr];

    always_comb begin
        cnt      = '0;
        rs1_pend = 1'b0;
        rs2_pend = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + BUF_CW'(vld[i]);
            if (vld[i] && mem[i].addr == rs1) rs1_pend = 1'b1;
            if (vld[i] && mem[i].addr == rs2) rs2_pend = 1'b1;
        end
        rs1_pend = rs1_pend && (rs1 != '0);
        rs2_pend = rs2_pend && (rs2 != '0);
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges ALU writeback and load-return onto the single register-file write port; runs clear.
// Latency: request accepted at edge N drives WriteReg/D in cycle N+1; read enables combinational.
// Backpressure: ALU stalls only in DRAIN/CLEAR; ld_ready drops when the buffer is full or in DRAIN/CLEAR.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    regfile_write_arbiter_if.slave wp,
    input  logic                  clr_req,
    output logic                  busy,
    input  reg_addr_t             rs1,
    input  reg_addr_t             rs2,
    output logic [NREG-1:0]       ReadEnable1,
    output logic [NREG-1:0]       ReadEnable2,
    output logic                  rs1_pend,
    output logic                  rs2_pend,
    output logic [NREG-1:0]       WriteReg,
    output data_t                 D
);
    localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);
    localparam reg_addr_t         LAST_REG = reg_addr_t'(NREG - 1);

    state_t            state_q, state_n;
    logic [WAIT_W-1:0] wait_q, wait_n, wait_inc;
    reg_addr_t         clr_q, clr_n;
    logic              alu_stall, ld_ready, ld_take;
    logic              iss_vld;
    wentry_t           iss;
    logic              buf_push, buf_pop, buf_flush, buf_empty, buf_full;
    logic [BUF_CW-1:0] buf_cnt;
    wentry_t           buf_head, ld_ent;

    assign ld_ent   = '{addr: wp.ld_waddr, data: wp.ld_wdata};
    assign wait_inc = wait_q + 1'b1;

    regfile_wbuf u_wbuf (
        .clk      (clk),
        .rst      (rst),
        .flush    (buf_flush),
        .push     (buf_push),
        .push_ent (ld_ent),
        .pop      (buf_pop),
        .head     (buf_head),
        .empty    (buf_empty),
        .full     (buf_full),
        .cnt      (buf_cnt),
        .rs1      (rs1),
        .rs2      (rs2),
        .rs1_pend (rs1_pend),
        .rs2_pend (rs2_pend)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            wait_q  <= '0;
            clr_q   <= '0;
        end else begin
            state_q <= state_n;
            wait_q  <= wait_n;
            clr_q   <= clr_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        wait_n    = wait_q;
        clr_n     = clr_q;
        iss_vld   = 1'b0;
        iss       = '0;
        buf_push  = 1'b0;
        buf_pop   = 1'b0;
        buf_flush = 1'b0;
        ld_take   = 1'b0;
        alu_stall = 1'b0;
        ld_ready  = 1'b0;
        busy      = 1'b0;
        case (state_q)
            RUN: begin
                ld_ready = !buf_full;
                ld_take  = wp.ld_valid && !buf_full;
                if (wp.alu_we) begin
                    iss_vld  = 1'b1;
                    iss      = '{addr: wp.alu_waddr, data: wp.alu_wdata};
                    buf_push = ld_take && (wp.ld_waddr != '0);
                end else if (!buf_empty) begin
                    iss_vld  = 1'b1;
                    iss      = buf_head;
                    buf_pop  = 1'b1;
                    buf_push = ld_take && (wp.ld_waddr != '0);
                end else if (ld_take) begin
                    iss_vld = 1'b1;
                    iss     = ld_ent;
                end
                // Age only counts cycles where an entry already sat at the head.
                if (buf_pop || buf_empty) begin
                    wait_n = '0;
                end else begin
                    wait_n = wait_inc;
                    if (wait_inc >= WAIT_LIM) state_n = DRAIN;
                end
            end
            DRAIN: begin
                alu_stall = 1'b1;
                wait_n    = '0;
                if (buf_empty) begin
                    state_n = RUN;
                end else begin
                    iss_vld = 1'b1;
                    iss     = buf_head;
                    buf_pop = 1'b1;
                    if (buf_cnt == BUF_CW'(1)) state_n = RUN;
                end
            end
            CLEAR: begin
                busy      = 1'b1;
                alu_stall = 1'b1;
                iss_vld   = 1'b1;
                iss.addr  = clr_q;
                clr_n     = clr_q + 4'd1;
                if (clr_q == LAST_REG) state_n = RUN;
            end
            default: state_n = RUN;
        endcase
        // This cycle's issue still completes; only the buffer contents are dropped.
        if (clr_req && state_q != CLEAR) begin
            state_n   = CLEAR;
            buf_flush = 1'b1;
            wait_n    = '0;
            clr_n     = 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WriteReg <= '0;
            D        <= '0;
        end else if (iss_vld && iss.addr != '0) begin
            WriteReg <= reg_onehot(iss.addr);
            D        <= iss.data;
        end else begin
            WriteReg <= '0;
        end
    end

    assign wp.alu_stall = alu_stall;
    assign wp.ld_ready  = ld_ready;
    assign ReadEnable1  = reg_onehot(rs1);
    assign ReadEnable2  = reg_onehot(rs2);
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed steps then random traffic against a queue-based model.
module tb_regfile_write_arbiter;
    localparam int BDEPTH = 2;
    localparam int BWAIT  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_req;
    logic [3:0]  rs1, rs2;
    logic        busy, rs1_pend, rs2_pend;
    logic [15:0] ReadEnable1, ReadEnable2, WriteReg, D;

    regfile_write_arbiter_if bus();

    regfile_write_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .wp          (bus),
        .clr_req     (clr_req),
        .busy        (busy),
        .rs1         (rs1),
        .rs2         (rs2),
        .ReadEnable1 (ReadEnable1),
        .ReadEnable2 (ReadEnable2),
        .rs1_pend    (rs1_pend),
        .rs2_pend    (rs2_pend),
        .WriteReg    (WriteReg),
        .D           (D)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  a;
        logic [15:0] d;
    } ent_t;

    ent_t        q[$];
    int          age;
    bit          drain;
    int          clr_next;
    logic [15:0] e_wr, e_d;
    bit          m_stall, m_ready;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] dec(input logic [3:0] r);
        logic [15:0] one;
        one = 16'h0001;
        return (r == 4'd0) ? 16'h0000 : (one << r);
    endfunction

    function automatic bit m_pend(input logic [3:0] r);
        if (r == 4'd0) return 1'b0;
        foreach (q[i]) if (q[i].a == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        q.delete();
        age = 0; drain = 0; clr_next = 0;
        e_wr = 16'h0; e_d = 16'h0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit          iv, had, was_clear, acc, popped;
        logic [3:0]  ia;
        logic [15:0] id;
        ent_t        h;
        iv = 0; ia = 0; id = 0; popped = 0;
        had = (q.size() > 0);
        was_clear = (clr_next != 0);
        if (was_clear) begin
            iv = 1; ia = 4'(clr_next); id = 16'h0;
            clr_next = (clr_next == 15) ? 0 : clr_next + 1;
        end else if (drain) begin
            h = q.pop_front();
            iv = 1; ia = h.a; id = h.d; age = 0;
            if (q.size() == 0) drain = 0;
        end else begin
            acc = bus.ld_valid && (q.size() < BDEPTH);
            if (bus.alu_we) begin
                iv = 1; ia = bus.alu_waddr; id = bus.alu_wdata;
            end else if (had) begin
                h = q.pop_front();
                iv = 1; ia = h.a; id = h.d; popped = 1;
            end else if (acc) begin
                iv = 1; ia = bus.ld_waddr; id = bus.ld_wdata; acc = 0;
            end
            if (acc && bus.ld_waddr != 4'd0) q.push_back('{a: bus.ld_waddr, d: bus.ld_wdata});
            if (popped) age = 0;
            else if (had) begin
                age++;
                if (age >= BWAIT) drain = 1;
            end else age = 0;
        end
        if (clr_req && !was_clear) begin
            q.delete(); age = 0; drain = 0; clr_next = 1;
        end
        if (iv && ia != 4'd0) begin
            e_wr = dec(ia); e_d = id;
        end else begin
            e_wr = 16'h0;
        end
    endtask

    task automatic cycle();
        #1;
        m_stall = (clr_next != 0) || drain;
        m_ready = !m_stall && (q.size() < BDEPTH);
        chk("alu_stall", 32'(bus.alu_stall), 32'(m_stall));
        chk("ld_ready", 32'(bus.ld_ready), 32'(m_ready));
        chk("busy", 32'(busy), 32'(clr_next != 0));
        chk("WriteReg", 32'(WriteReg), 32'(e_wr));
        chk("D", 32'(D), 32'(e_d));
        chk("ReadEnable1", 32'(ReadEnable1), 32'(dec(rs1)));
        chk("ReadEnable2", 32'(ReadEnable2), 32'(dec(rs2)));
        chk("rs1_pend", 32'(rs1_pend), 32'(m_pend(rs1)));
        chk("rs2_pend", 32'(rs2_pend), 32'(m_pend(rs2)));
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input bit aw, input logic [3:0] aa, input logic [15:0] ad,
                         input bit lv, input logic [3:0] la, input logic [15:0] ldat);
        bus.alu_we = aw; bus.alu_waddr = aa; bus.alu_wdata = ad;
        bus.ld_valid = lv; bus.ld_waddr = la; bus.ld_wdata = ldat;
    endtask

    task automatic do_reset(input string tag);
        #2 rst = 1'b0;
        #1;
        chk({tag, "_WriteReg"}, 32'(WriteReg), 32'h0);
        chk({tag, "_D"}, 32'(D), 32'h0);
        chk({tag, "_alu_stall"}, 32'(bus.alu_stall), 32'h0);
        chk({tag, "_ld_ready"}, 32'(bus.ld_ready), 32'h1);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_rs1_pend"}, 32'(rs1_pend), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int          nst, nbusy, k;
        logic [3:0]  la[3];
        logic [15:0] ldd[3];

        rst = 1'b0; clr_req = 1'b0; rs1 = 4'd0; rs2 = 4'd0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        #3;
        chk("rst_WriteReg", 32'(WriteReg), 32'h0);
        chk("rst_ld_ready", 32'(bus.ld_ready), 32'h1);
        chk("rst_alu_stall", 32'(bus.alu_stall), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // ALU only
        drive(1, 4'd3, 16'hBEEF, 0, 0, 0);
        cycle();
        chk("alu_wr", 32'(WriteReg), 32'h0008);
        chk("alu_d", 32'(D), 32'hBEEF);
        drive(0, 0, 0, 0, 0, 0);
        cycle();

        // Collision: ALU first, buffered load next
        rs1 = 4'd5;
        drive(1, 4'd2, 16'h1111, 1, 4'd5, 16'h2222);
        cycle();
        chk("col_alu_wr", 32'(WriteReg), 32'h0004);
        chk("col_pend", 32'(rs1_pend), 32'h1);
        drive(0, 0, 0, 0, 0, 0);
        cycle();
        chk("col_ld_wr", 32'(WriteReg), 32'h0020);
        chk("col_ld_d", 32'(D), 32'h2222);
        chk("col_pend_clr", 32'(rs1_pend), 32'h0);

        // Starvation forces a one-cycle drain
        drive(1, 4'd2, 16'h1111, 1, 4'd5, 16'h2222);
        cycle();
        drive(1, 4'd6, 16'h6666, 0, 0, 0);
        nst = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.alu_stall) nst++;
            cycle();
        end
        chk("starve_stall_cycles", 32'(nst), 32'd1);
        drive(0, 0, 0, 0, 0, 0);
        cycle();

        // Overflow: third load must be held, not lost
        la[0] = 4'd7; la[1] = 4'd8; la[2] = 4'd9;
        ldd[0] = 16'h7777; ldd[1] = 16'h8888; ldd[2] = 16'h9999;
        k = 0;
        for (int i = 0; i < 12; i++) begin
            if (k < 3) drive(1, 4'd10, 16'hA0A0, 1, la[k], ldd[k]);
            else drive(1, 4'd10, 16'hA0A0, 0, 0, 0);
            if (i == 2) chk("ovf_ready", 32'(bus.ld_ready), 32'h0);
            cycle();
            if (bus.ld_valid && m_ready) k++;
        end
        chk("ovf_all_taken", 32'(k), 32'd3);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle();

        // Clear with one buffered entry
        drive(1, 4'd2, 16'h1111, 1, 4'd5, 16'h2222);
        cycle();
        drive(1, 4'd4, 16'h4444, 0, 0, 0);
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        chk("clr_discard_pend", 32'(rs1_pend), 32'h0);
        nbusy = 0;
        for (int j = 0; j < 20; j++) begin
            if (busy) nbusy++;
            cycle();
            if (j < 15) begin
                chk("clr_walk", 32'(WriteReg), 32'h1 << (j + 1));
                chk("clr_d", 32'(D), 32'h0);
            end
        end
        chk("clr_busy_cycles", 32'(nbusy), 32'd15);

        // R0 writes are accepted and dropped
        drive(1, 4'd0, 16'hFFFF, 0, 0, 0);
        cycle();
        chk("r0_alu_wr", 32'(WriteReg), 32'h0);
        drive(0, 0, 0, 1, 4'd0, 16'h1234);
        cycle();
        chk("r0_ld_wr", 32'(WriteReg), 32'h0);
        chk("r0_ld_d", 32'(D), 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        cycle();

        // Reset mid-CLEAR
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        do_reset("rst_clear");
        cycle();

        // Reset mid-DRAIN with a pending entry
        drive(1, 4'd2, 16'h1111, 1, 4'd5, 16'h2222);
        cycle();
        drive(1, 4'd6, 16'h6666, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle();
        chk("pre_rst_drain_stall", 32'(bus.alu_stall), 32'h1);
        drive(0, 0, 0, 0, 0, 0);
        do_reset("rst_drain");
        cycle();

        // Random traffic with held requests
        for (int n = 0; n < 400; n++) begin
            cycle();
            if (!(bus.alu_we && m_stall)) begin
                bus.alu_we    = ($urandom_range(0, 9) < 6);
                bus.alu_waddr = 4'($urandom_range(0, 15));
                bus.alu_wdata = 16'($urandom);
            end
            if (!(bus.ld_valid && !m_ready)) begin
                bus.ld_valid = ($urandom_range(0, 9) < 5);
                bus.ld_waddr = 4'($urandom_range(0, 15));
                bus.ld_wdata = 16'($urandom);
            end
            clr_req = ($urandom_range(0, 49) == 0);
            rs1 = 4'($urandom_range(0, 15));
            rs2 = 4'($urandom_range(0, 15));
        end
        clr_req = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
